gbuf_banked: RTL and testbench

//  Multi-bank global buffer for the NPU datapath; generalises the single-port gbuff.

---
 rtl/gbuf_banked.sv | 133 +++++++++++++
 tb/tb_gbuf_banked.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbuf_banked.sv
// rtl/gbuf_banked.sv - banked global buffer with sequential clear; optional macro GBUF_WR_FWD_EN enables same-address write-to-read forwarding
module gbuf_banked #(
    parameter int ADDR  = 8,
    parameter int DATA  = 32,
    parameter int BANKS = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_req_i,
    output logic            clr_busy_o,
    input  logic            wr_valid_i,
    output logic            wr_ready_o,
    input  logic [ADDR-1:0] wr_addr_i,
    input  logic [DATA-1:0] wr_data_i,
    input  logic            rd_valid_i,
    output logic            rd_ready_o,
    input  logic [ADDR-1:0] rd_addr_i,
    output logic            rdata_valid_o,
    output logic [DATA-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR;
    localparam int ROWS  = DEPTH / BANKS;
    localparam int LB    = $clog2(BANKS);
    localparam int BW    = (LB > 0) ? LB : 1;
    localparam int RW    = (ADDR - LB > 0) ? (ADDR - LB) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    // Low address bits pick the bank so consecutive words spread across banks.
    function automatic logic [BW-1:0] bank_of(input logic [ADDR-1:0] a);
        if (LB == 0) return '0;
        else         return a[BW-1:0];
    endfunction

    function automatic logic [RW-1:0] row_of(input logic [ADDR-1:0] a);
        return RW'(a >> LB);
    endfunction

    state_t          state_q, state_d;
    logic [RW-1:0]   clr_row_q, clr_row_d;
    logic [DATA-1:0] mem_q [BANKS][ROWS];
    logic [DATA-1:0] rdata_q;
    logic            rdata_valid_q;

    logic            same_bank;
    logic            conflict;
    logic            wr_fire;
    logic            rd_fire;
    logic [DATA-1:0] rd_word;

    assign same_bank = wr_valid_i && (bank_of(wr_addr_i) == bank_of(rd_addr_i));
`ifdef GBUF_WR_FWD_EN
    // A same-address pair is served by forwarding, so only a different row in the bank stalls.
    assign conflict  = same_bank && (wr_addr_i != rd_addr_i);
    assign rd_word   = (wr_valid_i && (wr_addr_i == rd_addr_i)) ?
                       wr_data_i : mem_q[bank_of(rd_addr_i)][row_of(rd_addr_i)];
`else
    assign conflict  = same_bank;
    assign rd_word   = mem_q[bank_of(rd_addr_i)][row_of(rd_addr_i)];
`endif

    assign wr_fire       = wr_valid_i && wr_ready_o;
    assign rd_fire       = rd_valid_i && rd_ready_o;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;

    // State register; reset always restarts the clear sweep from row 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_CLEAR;
            clr_row_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_row_q <= clr_row_d;
        end
    end

    // Next state and handshake outputs; writes always win a bank, reads stall.
    always_comb begin
        state_d    = state_q;
        clr_row_d  = clr_row_q;
        clr_busy_o = 1'b0;
        wr_ready_o = 1'b0;
        rd_ready_o = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_busy_o = 1'b1;
                clr_row_d  = clr_row_q + 1'b1;
                if (clr_row_q == LAST_ROW) begin
                    state_d   = ST_IDLE;
                    clr_row_d = '0;
                end
            end
            ST_IDLE: begin
                wr_ready_o = !clr_req_i;
                rd_ready_o = !clr_req_i && !conflict;
                if (clr_req_i) begin
                    state_d   = ST_CLEAR;
                    clr_row_d = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Bank storage: one port per bank, used by either the clear sweep or a write.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < BANKS; b++) begin
            if (state_q == ST_CLEAR) begin
                mem_q[b][clr_row_q] <= '0;
            end else if (wr_fire && (bank_of(wr_addr_i) == BW'(b))) begin
                mem_q[b][row_of(wr_addr_i)] <= wr_data_i;
            end
        end
    end

    // Registered read data held until the next accepted read; valid pulses once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            rdata_valid_q <= rd_fire;
            if (rd_fire) rdata_q <= rd_word;
        end
    end

endmodule

// File: tb/tb_gbuf_banked.sv
// tb/tb_gbuf_banked.sv - self-checking bench for gbuf_banked with ADDR=4, BANKS=4
module tb_gbuf_banked;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_req;
    logic        clr_busy;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [3:0]  rd_addr;
    logic        rdata_valid;
    logic [31:0] rdata;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] ref_mem [16];

`ifdef GBUF_WR_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    gbuf_banked #(.ADDR(4), .DATA(32), .BANKS(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clr_req_i    (clr_req),
        .clr_busy_o   (clr_busy),
        .wr_valid_i   (wr_valid),
        .wr_ready_o   (wr_ready),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .rd_valid_i   (rd_valid),
        .rd_ready_o   (rd_ready),
        .rd_addr_i    (rd_addr),
        .rdata_valid_o(rdata_valid),
        .rdata_o      (rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_model();
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, output logic rdy);
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        #1 rdy = wr_ready;
        @(posedge clk);
        #1 wr_valid = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic do_read(input logic [3:0] a, output logic rdy, output logic vld,
                           output logic [31:0] d);
        @(negedge clk);
        rd_valid = 1'b1; rd_addr = a;
        #1 rdy = rd_ready;
        @(posedge clk);
        #1 vld = rdata_valid; d = rdata;
        rd_valid = 1'b0;
    endtask

    // Counts negedge samples with clr_busy high, starting right after reset release.
    task automatic wait_clear(output int cycles, output logic ready_seen);
        cycles = 0; ready_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!clr_busy) break;
            cycles++;
            if (wr_ready || rd_ready) ready_seen = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int cyc; logic rs; logic rdy, vld; logic [31:0] d;
        rst = 1'b1; clr_req = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({clr_busy, wr_ready, rd_ready, rdata_valid} !== 4'b1000 || rdata !== 32'h0)
            $display("FAIL reset_outputs: busy/wr/rd/vld=%b rdata=%h, required 1000 and 0",
                     {clr_busy, wr_ready, rd_ready, rdata_valid}, rdata);
        else n_pass++;
        @(negedge clk); rst = 1'b0;
        wait_clear(cyc, rs);
        clear_model();
        n_checks++;
        if (cyc !== 4) $display("FAIL clear_len: busy for %0d cycles, required 4", cyc);
        else n_pass++;
        n_checks++;
        if (rs !== 1'b0) $display("FAIL clear_ready: ready seen during clear, required none");
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i), rdy, vld, d);
            n_checks++;
            if (!(rdy === 1'b1 && vld === 1'b1 && d === ref_mem[i]))
                $display("FAIL init_read@%0d: rdy=%b vld=%b data=%h, required 1 1 %h",
                         i, rdy, vld, d, ref_mem[i]);
            else n_pass++;
        end
    endtask

    task automatic test_write_read();
        logic rdy, vld; logic [31:0] d;
        do_write(4'd5, 32'hDEADBEEF, rdy);
        n_checks++;
        if (rdy !== 1'b1) $display("FAIL wr_ready@5: got %b, required 1", rdy);
        else n_pass++;
        do_read(4'd5, rdy, vld, d);
        n_checks++;
        if (!(rdy === 1'b1 && vld === 1'b1 && d === 32'hDEADBEEF))
            $display("FAIL read@5: rdy=%b vld=%b data=%h, required 1 1 deadbeef", rdy, vld, d);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (rdata_valid !== 1'b0 || rdata !== 32'hDEADBEEF)
            $display("FAIL rvalid_drop: vld=%b data=%h, required 0 deadbeef", rdata_valid, rdata);
        else n_pass++;
    endtask

    task automatic test_diff_bank();
        logic wr0, rr0; logic rdy, vld; logic [31:0] d;
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 32'h11;
        rd_valid = 1'b1; rd_addr = 4'd7;
        #1 wr0 = wr_ready; rr0 = rd_ready;
        @(posedge clk); #1;
        wr_valid = 1'b0; rd_valid = 1'b0;
        n_checks++;
        if (!(wr0 === 1'b1 && rr0 === 1'b1 && rdata_valid === 1'b1 && rdata === ref_mem[7]))
            $display("FAIL diff_bank: wr=%b rd=%b vld=%b data=%h, required 1 1 1 %h",
                     wr0, rr0, rdata_valid, rdata, ref_mem[7]);
        else n_pass++;
        ref_mem[2] = 32'h11;
        do_read(4'd2, rdy, vld, d);
        n_checks++;
        if (!(rdy === 1'b1 && vld === 1'b1 && d === 32'h11))
            $display("FAIL read@2: rdy=%b vld=%b data=%h, required 1 1 11", rdy, vld, d);
        else n_pass++;
    endtask

    task automatic test_conflict();
        logic rr0, rr1;
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 4'd1; wr_data = 32'h22;
        rd_valid = 1'b1; rd_addr = 4'd5;
        #1 rr0 = rd_ready;
        @(posedge clk); #1;
        wr_valid = 1'b0; ref_mem[1] = 32'h22;
        n_checks++;
        if (rr0 !== 1'b0 || rdata_valid !== 1'b0)
            $display("FAIL conflict_stall: rd_ready=%b vld=%b, required 0 0", rr0, rdata_valid);
        else n_pass++;
        @(negedge clk); #1 rr1 = rd_ready;
        @(posedge clk); #1;
        rd_valid = 1'b0;
        n_checks++;
        if (!(rr1 === 1'b1 && rdata_valid === 1'b1 && rdata === ref_mem[5]))
            $display("FAIL conflict_retry: rd=%b vld=%b data=%h, required 1 1 %h",
                     rr1, rdata_valid, rdata, ref_mem[5]);
        else n_pass++;
    endtask

    task automatic test_same_addr();
        logic rr0, v0, rr1; logic [31:0] d0;
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 4'd6; wr_data = 32'h33;
        rd_valid = 1'b1; rd_addr = 4'd6;
        #1 rr0 = rd_ready;
        @(posedge clk); #1;
        v0 = rdata_valid; d0 = rdata;
        wr_valid = 1'b0; ref_mem[6] = 32'h33;
`ifdef GBUF_WR_FWD_EN
        rd_valid = 1'b0;
        n_checks++;
        if (!(rr0 === 1'b1 && v0 === 1'b1 && d0 === 32'h33))
            $display("FAIL same_addr_fwd: rd=%b vld=%b data=%h, required 1 1 33", rr0, v0, d0);
        else n_pass++;
`else
        n_checks++;
        if (rr0 !== 1'b0 || v0 !== 1'b0)
            $display("FAIL same_addr_stall: rd=%b vld=%b, required 0 0", rr0, v0);
        else n_pass++;
        @(negedge clk); #1 rr1 = rd_ready;
        @(posedge clk); #1;
        rd_valid = 1'b0;
        n_checks++;
        if (!(rr1 === 1'b1 && rdata_valid === 1'b1 && rdata === 32'h33))
            $display("FAIL same_addr_retry: rd=%b vld=%b data=%h, required 1 1 33",
                     rr1, rdata_valid, rdata);
        else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic wv, rv, exp_rr, exp_fire, obs_wr, obs_rr;
        logic [3:0] wa, ra;
        logic [31:0] wd, exp_d;
        for (int it = 0; it < 300; it++) begin
            @(negedge clk);
            wv = 1'($urandom_range(0, 1)); rv = 1'($urandom_range(0, 1));
            wa = 4'($urandom_range(0, 15)); ra = 4'($urandom_range(0, 15));
            wd = $urandom;
            wr_valid = wv; wr_addr = wa; wr_data = wd;
            rd_valid = rv; rd_addr = ra;
            exp_rr   = !(wv && (wa % 4) == (ra % 4) && !(FWD && wa == ra));
            exp_fire = rv && exp_rr;
            exp_d    = (FWD && wv && wa == ra) ? wd : ref_mem[ra];
            #1 obs_wr = wr_ready; obs_rr = rd_ready;
            n_checks++;
            if (obs_wr !== 1'b1 || obs_rr !== exp_rr)
                $display("FAIL rand_ready[%0d]: wr=%b rd=%b, required 1 %b", it, obs_wr, obs_rr, exp_rr);
            else n_pass++;
            @(posedge clk); #1;
            if (wv) ref_mem[wa] = wd;
            n_checks++;
            if (rdata_valid !== exp_fire || (exp_fire && rdata !== exp_d))
                $display("FAIL rand_read[%0d]: vld=%b data=%h, required %b %h",
                         it, rdata_valid, rdata, exp_fire, exp_d);
            else n_pass++;
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        int cyc; logic rs; logic rdy, vld; logic [31:0] d;
        for (int i = 0; i < 16; i++) do_write(4'(i), $urandom | 32'h1, rdy);
        do_read(4'd3, rdy, vld, d);
        n_checks++;
        if (!(rdy === 1'b1 && vld === 1'b1 && d === ref_mem[3]))
            $display("FAIL fill_read@3: rdy=%b vld=%b data=%h, required 1 1 %h",
                     rdy, vld, d, ref_mem[3]);
        else n_pass++;
        @(negedge clk); clr_req = 1'b1;
        #1;
        n_checks++;
        if (wr_ready !== 1'b0 || clr_busy !== 1'b0)
            $display("FAIL clr_req_gate: wr_ready=%b busy=%b, required 0 0", wr_ready, clr_busy);
        else n_pass++;
        @(negedge clk); clr_req = 1'b0;
        #1;
        n_checks++;
        if (clr_busy !== 1'b1) $display("FAIL clr_start: busy=%b, required 1", clr_busy);
        else n_pass++;
        @(negedge clk); rst = 1'b1;
        #1;
        n_checks++;
        if (rdata_valid !== 1'b0 || rdata !== 32'h0 || clr_busy !== 1'b1)
            $display("FAIL mid_clear_rst: vld=%b data=%h busy=%b, required 0 0 1",
                     rdata_valid, rdata, clr_busy);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_clear(cyc, rs);
        clear_model();
        n_checks++;
        if (cyc !== 4 || rs !== 1'b0)
            $display("FAIL restart_len: busy %0d cycles ready_seen=%b, required 4 0", cyc, rs);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i), rdy, vld, d);
            n_checks++;
            if (!(rdy === 1'b1 && vld === 1'b1 && d === ref_mem[i]))
                $display("FAIL post_clear@%0d: rdy=%b vld=%b data=%h, required 1 1 %h",
                         i, rdy, vld, d, ref_mem[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_diff_bank();
        test_conflict();
        test_same_addr();
        test_random();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
